flog_base_conv: RTL and testbench
=================================

# flog_base_conv

Downstream post-processing stage for the bfloat16 log2 unit (`top_top`): takes each log2 result and rescales it to log2, ln or log10 by multiplying with a fixed bfloat16-domain constant, rounding round-to-nearest-even. The block is a 2-stage pipeline, accepts one result per cycle and uses valid/ready handshaking on both sides. It sits between `top_top` outputs and the result sink or bus interface.

## Interface
Parameters (defaults from `flog_pkg`):
- `EXP_WIDTH`, 8: exponent width.
- `FRACT_WIDTH`, 7: stored fraction width.
- `CONST_WIDTH`, 16: significand width of the conversion constants, 1 integer + 15 fraction bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_op_i`  in  1  log2 result sign.
- `e_op_i`  in  EXP_WIDTH  log2 result exponent.
- `f_op_i`  in  FRACT_WIDTH  log2 result fraction.
- `base_sel_i`  in  2  target base: 0 = log2 (pass-through), 1 = ln, 2 = log10, 3 = treated as 0.
- `valid_i`  in  1  operand valid.
- `ready_o`  out  1  operand accepted when `valid_i && ready_o`.
- `s_res_o`, `e_res_o`, `f_res_o`  out  1 / EXP_WIDTH / FRACT_WIDTH  converted result.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  result consumed when `valid_o && ready_i`.

## Operation
- Input classes, decoded in stage 1:
  - e = 255, f = 0: ±inf. Output is the same value.
  - e = 255, f ≠ 0: NaN. Output is canonical qNaN s=0, e=255, f=1000000.
  - e = 0: zero or subnormal. Output is signed zero with the same sign (flush-to-zero).
  - Otherwise: normal.
- Pass-through (sel 0 or 3): normal inputs are output unchanged, with the same latency.
- Multiply (sel 1 or 2): the 8-bit significand {1,f} is multiplied by the constant significand K (16 bits), giving a 24-bit product with 22 fraction bits.
  - ln: K = `LN2_SIG` = 0xB172, `LN2_EOFF` = −1.
  - log10: K = `LOG10_2_SIG` = 0x9A21, `LOG10_2_EOFF` = −2.
- Normalize: if product bit 23 is set, shift right by 1 and add 1 to the exponent.
- Round RNE to 7 fraction bits using the guard bit and the OR of the remaining bits (sticky). A rounding carry-out gives fraction 0 and adds 1 to the exponent.
- Exponent: e_out = e_in + EOFF + norm + carry, computed at 10-bit signed width.
  - e_out ≤ 0: flush to signed zero.
  - Overflow cannot occur, because both constants are < 1.
- Sign is passed through unchanged.
- `base_sel_i` is captured together with the operand at acceptance. Changing it later affects only later operands.

## Timing
- Latency: exactly 2 cycles from acceptance to `valid_o` when `ready_i` stays high. Throughput is 1 result per cycle.
- Stage 1 registers the operand, class, selection and raw product. Stage 2 registers the normalized, rounded, packed result.
- Stall rule:
  - Global enable `en = !valid_o || ready_i`.
  - `ready_o = !rst && en`.
  - While `en` is low, both stages hold. `valid_o` and the result stay stable until consumed, with no loss and no reordering.
- Upstream keeps operand fields and `base_sel_i` stable while `valid_i && !ready_o`.
- Reset, synchronous and active-high: on the first edge with `rst` high, both stage valids, `valid_o`, `s_res_o`, `e_res_o` and `f_res_o` clear to 0.
  - Data in flight is discarded; nothing is emitted for it.
  - `ready_o` is 0 while `rst` is high and 1 on the cycle after reset deasserts.
- Simultaneous accept and consume in one cycle is legal and keeps full throughput.

## Structure
- Add to `flog_pkg`:
  - `CONST_WIDTH`.
  - `LN2_SIG`, `LOG10_2_SIG`, `LN2_EOFF`, `LOG10_2_EOFF`.
  - Enum `base_sel_t` (`BASE_LOG2`, `BASE_LN`, `BASE_LOG10`).
  - Class enum `fclass_t` (`FC_ZERO`, `FC_NORM`, `FC_INF`, `FC_NAN`).
  - Canonical qNaN constants.
- One sub-module, `flog_norm_rne`. It is combinational: input is the 24-bit product and exponent; output is the packed exponent and fraction plus the flush flag. It is used in stage 2.
- Top `flog_base_conv` holds the class decode, constant mux, multiplier, pipeline registers and handshake.

## Test plan
- ln, (0,127,0000000) = 1.0 → (0,126,0110001) ≈ 0.6931. `valid_o` rises exactly 2 cycles after acceptance.
- log10, (0,130,0000000) = 8.0 → (0,128,0011010) ≈ 2.406.
- Special cases under ln:
  - (1,255,0000000) → (1,255,0000000).
  - (0,255,0111111) → (0,255,1000000).
  - (0,0,0000000) → (0,0,0000000).
  - (1,0,0101010) → (1,0,0000000).
- Pass-through, sel 0 then sel 3, (0,251,0101011) → identical output, 2-cycle latency. Back-to-back operands with alternating `base_sel_i` give correct per-operand results.
- Backpressure: 4 operands back-to-back, `ready_i` = 0 for 5 cycles after the first `valid_o`. Required:
  - `ready_o` drops.
  - Output stays stable.
  - All 4 results arrive in order, with no duplicates.
- Reset mid-flight with 2 operands in the pipe: `valid_o` = 0 and outputs zero on the next cycle. Neither result ever appears. The first operand after reset completes with 2-cycle latency.
- Random sweep: 1000 normal operands × 3 bases, compared against a reference model (log2 × constant, RNE to bfloat16). Mismatches must be 0.

Source files
------------

// File: rtl/flog_pkg.sv
// -----------------------------------------------------------------------------
// flog_pkg
// Shared definitions for the bfloat16 log unit and its base-conversion stage:
// field widths, conversion constants for rescaling log2 results to ln and
// log10, the base-select and operand-class enums, and the canonical quiet NaN.
// -----------------------------------------------------------------------------
package flog_pkg;

  // bfloat16 field widths
  localparam int EXP_WIDTH   = 8;
  localparam int FRACT_WIDTH = 7;

  // Conversion constant significands: 1 integer bit + 15 fraction bits
  localparam int CONST_WIDTH = 16;

  // Signed width used for exponent arithmetic (room for sign and one carry)
  localparam int EXP_CALC_WIDTH = EXP_WIDTH + 2;

  // ln(2)     = 0xB172 / 2^15 * 2^-1  (1.3863 * 0.5)
  // log10(2)  = 0x9A21 / 2^15 * 2^-2  (1.2041 * 0.25)
  localparam logic [CONST_WIDTH-1:0]           LN2_SIG      = 16'hB172;
  localparam logic [CONST_WIDTH-1:0]           LOG10_2_SIG  = 16'h9A21;
  localparam logic signed [EXP_CALC_WIDTH-1:0] LN2_EOFF     = -10'sd1;
  localparam logic signed [EXP_CALC_WIDTH-1:0] LOG10_2_EOFF = -10'sd2;

  // Target base of the conversion
  typedef enum logic [1:0] {
    BASE_LOG2  = 2'd0,
    BASE_LN    = 2'd1,
    BASE_LOG10 = 2'd2
  } base_sel_t;

  // Operand class, decoded once at the pipeline entry
  typedef enum logic [1:0] {
    FC_ZERO = 2'd0,
    FC_NORM = 2'd1,
    FC_INF  = 2'd2,
    FC_NAN  = 2'd3
  } fclass_t;

  // Canonical quiet NaN
  localparam logic                   QNAN_S = 1'b0;
  localparam logic [EXP_WIDTH-1:0]   QNAN_E = 8'hFF;
  localparam logic [FRACT_WIDTH-1:0] QNAN_F = 7'b1000000;

  // Raw select code 3 is folded onto log2 so downstream logic only ever
  // sees the three legal enum values.
  function automatic base_sel_t decode_base_sel(input logic [1:0] sel);
    case (sel)
      2'd1:    return BASE_LN;
      2'd2:    return BASE_LOG10;
      default: return BASE_LOG2;
    endcase
  endfunction

endpackage

// File: rtl/flog_norm_rne.sv
// -----------------------------------------------------------------------------
// flog_norm_rne
// Combinational normalize + round-to-nearest-even for the base conversion.
// The product of the 8-bit significand and the 16-bit constant lies in
// [1, 4), so its leading one is in one of the top two bits.
//
// Ports:
//   prod      in   significand product, 2 integer bits + (FRACT+15) fraction
//   exp_base  in   signed input exponent already offset by the constant's EOFF
//   e_res     out  packed result exponent (valid when flush is low)
//   f_res     out  rounded stored fraction (valid when flush is low)
//   flush     out  result exponent <= 0, caller must emit signed zero
// -----------------------------------------------------------------------------
module flog_norm_rne
  import flog_pkg::*;
#(
  parameter int EXP_WIDTH   = flog_pkg::EXP_WIDTH,
  parameter int FRACT_WIDTH = flog_pkg::FRACT_WIDTH,
  parameter int CONST_WIDTH = flog_pkg::CONST_WIDTH
) (
  input  logic [FRACT_WIDTH+CONST_WIDTH:0] prod,
  input  logic signed [EXP_WIDTH+1:0]      exp_base,
  output logic [EXP_WIDTH-1:0]             e_res,
  output logic [FRACT_WIDTH-1:0]           f_res,
  output logic                             flush
);

  localparam int PW = FRACT_WIDTH + CONST_WIDTH + 1;
  localparam int CW = EXP_WIDTH + 2;

  logic                 norm;
  logic [FRACT_WIDTH-1:0] frac_t;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [FRACT_WIDTH:0] frac_r;
  logic signed [CW-1:0] inc;
  logic signed [CW-1:0] exp_sum;

  // When the top bit is set the value is in [2,4): the kept fraction, guard
  // and sticky windows all slide up by one bit and the exponent gains one.
  always_comb begin
    norm = prod[PW-1];
    if (norm) begin
      frac_t = prod[PW-2 -: FRACT_WIDTH];
      guard  = prod[PW-2-FRACT_WIDTH];
      sticky = |prod[PW-3-FRACT_WIDTH:0];
    end else begin
      frac_t = prod[PW-3 -: FRACT_WIDTH];
      guard  = prod[PW-3-FRACT_WIDTH];
      sticky = |prod[PW-4-FRACT_WIDTH:0];
    end

    // Ties go to the even fraction
    round_up = guard & (sticky | frac_t[0]);
    frac_r   = {1'b0, frac_t} + (FRACT_WIDTH+1)'(round_up);

    // A carry out of the fraction leaves it all zeros and bumps the exponent
    inc     = CW'(norm) + CW'(frac_r[FRACT_WIDTH]);
    exp_sum = exp_base + inc;

    flush = exp_sum[CW-1] || (exp_sum == '0);
    e_res = exp_sum[EXP_WIDTH-1:0];
    f_res = frac_r[FRACT_WIDTH-1:0];
  end

endmodule

// File: rtl/flog_base_conv.sv
// -----------------------------------------------------------------------------
// flog_base_conv
// Rescales bfloat16 log2 results to log2 / ln / log10 by multiplying with a
// fixed constant, rounding RNE. Two-stage pipeline, one result per cycle,
// valid/ready on both sides with a single global stall enable.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_op_i, e_op_i, f_op_i    log2 result operand (sign, exponent, fraction)
//   base_sel_i                0 = log2, 1 = ln, 2 = log10, 3 = log2
//   valid_i / ready_o         operand handshake
//   s_res_o, e_res_o, f_res_o converted result
//   valid_o / ready_i         result handshake
// -----------------------------------------------------------------------------
module flog_base_conv
  import flog_pkg::*;
#(
  parameter int EXP_WIDTH   = flog_pkg::EXP_WIDTH,
  parameter int FRACT_WIDTH = flog_pkg::FRACT_WIDTH,
  parameter int CONST_WIDTH = flog_pkg::CONST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_op_i,
  input  logic [EXP_WIDTH-1:0]   e_op_i,
  input  logic [FRACT_WIDTH-1:0] f_op_i,
  input  logic [1:0]             base_sel_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   s_res_o,
  output logic [EXP_WIDTH-1:0]   e_res_o,
  output logic [FRACT_WIDTH-1:0] f_res_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int PROD_WIDTH = FRACT_WIDTH + 1 + CONST_WIDTH;
  localparam int CALC_WIDTH = EXP_WIDTH + 2;

  // Whole pipeline advances together; it only stops when a result is
  // waiting at the output and the sink is not taking it.
  logic en;
  assign en      = !valid_o || ready_i;
  assign ready_o = !rst && en;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: class decode, constant select, multiply
  // ---------------------------------------------------------------------------
  fclass_t                class_c;
  base_sel_t              sel_c;
  logic [CONST_WIDTH-1:0] k_c;
  logic [PROD_WIDTH-1:0]  prod_c;

  always_comb begin
    class_c = FC_NORM;
    if (&e_op_i) begin
      class_c = (|f_op_i) ? FC_NAN : FC_INF;
    end else if (e_op_i == '0) begin
      class_c = FC_ZERO;
    end

    sel_c = decode_base_sel(base_sel_i);

    // The log2 path never uses the product, so it shares the ln constant
    k_c = (sel_c == BASE_LOG10) ? CONST_WIDTH'(LOG10_2_SIG) : CONST_WIDTH'(LN2_SIG);

    prod_c = PROD_WIDTH'({1'b1, f_op_i}) * PROD_WIDTH'(k_c);
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic                   s1_valid;
  logic                   s1_s;
  logic [EXP_WIDTH-1:0]   s1_e;
  logic [FRACT_WIDTH-1:0] s1_f;
  fclass_t                s1_class;
  base_sel_t              s1_sel;
  logic [PROD_WIDTH-1:0]  s1_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= 1'b0;
      s1_e     <= '0;
      s1_f     <= '0;
      s1_class <= FC_ZERO;
      s1_sel   <= BASE_LOG2;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= valid_i;
      s1_s     <= s_op_i;
      s1_e     <= e_op_i;
      s1_f     <= f_op_i;
      s1_class <= class_c;
      s1_sel   <= sel_c;
      s1_prod  <= prod_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: exponent offset, normalize/round, result select
  // ---------------------------------------------------------------------------
  logic signed [CALC_WIDTH-1:0] eoff_c;
  logic signed [CALC_WIDTH-1:0] exp_base_c;
  logic [EXP_WIDTH-1:0]         e_norm;
  logic [FRACT_WIDTH-1:0]       f_norm;
  logic                         flush;

  always_comb begin
    eoff_c     = (s1_sel == BASE_LOG10) ? CALC_WIDTH'(LOG10_2_EOFF) : CALC_WIDTH'(LN2_EOFF);
    exp_base_c = $signed(CALC_WIDTH'(s1_e)) + eoff_c;
  end

  flog_norm_rne #(
    .EXP_WIDTH   (EXP_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH),
    .CONST_WIDTH (CONST_WIDTH)
  ) u_norm_rne (
    .prod     (s1_prod),
    .exp_base (exp_base_c),
    .e_res    (e_norm),
    .f_res    (f_norm),
    .flush    (flush)
  );

  logic                   res_s;
  logic [EXP_WIDTH-1:0]   res_e;
  logic [FRACT_WIDTH-1:0] res_f;

  // Specials bypass the multiplier; normals either pass through (log2) or
  // take the rounded product, flushing to signed zero on exponent underflow.
  always_comb begin
    res_s = s1_s;
    res_e = s1_e;
    res_f = s1_f;
    case (s1_class)
      FC_NAN: begin
        res_s = QNAN_S;
        res_e = {EXP_WIDTH{1'b1}};
        res_f = {1'b1, {(FRACT_WIDTH-1){1'b0}}};
      end
      FC_INF: begin
        res_e = {EXP_WIDTH{1'b1}};
        res_f = '0;
      end
      FC_ZERO: begin
        res_e = '0;
        res_f = '0;
      end
      default: begin
        if (s1_sel != BASE_LOG2) begin
          if (flush) begin
            res_e = '0;
            res_f = '0;
          end else begin
            res_e = e_norm;
            res_f = f_norm;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      s_res_o <= 1'b0;
      e_res_o <= '0;
      f_res_o <= '0;
    end else if (en) begin
      valid_o <= s1_valid;
      s_res_o <= res_s;
      e_res_o <= res_e;
      f_res_o <= res_f;
    end
  end

endmodule

// File: tb/tb_flog_base_conv.sv
// -----------------------------------------------------------------------------
// tb_flog_base_conv
// Self-checking bench for flog_base_conv: directed literal cases, a stream
// scoreboard fed by an arithmetic reference model, backpressure, mid-flight
// reset and a random sweep over all three bases.
// -----------------------------------------------------------------------------
module tb_flog_base_conv;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_op_i;
  logic [7:0] e_op_i;
  logic [6:0] f_op_i;
  logic [1:0] base_sel_i;
  logic       valid_i;
  logic       ready_o;
  logic       s_res_o;
  logic [7:0] e_res_o;
  logic [6:0] f_res_o;
  logic       valid_o;
  logic       ready_i;

  int          checks  = 0;
  int          fails   = 0;
  int          emitted = 0;
  logic [15:0] exp_q[$];
  bit          sweep_on = 1'b0;

  always #5 clk = ~clk;

  flog_base_conv dut (
    .clk        (clk),
    .rst        (rst),
    .s_op_i     (s_op_i),
    .e_op_i     (e_op_i),
    .f_op_i     (f_op_i),
    .base_sel_i (base_sel_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .s_res_o    (s_res_o),
    .e_res_o    (e_res_o),
    .f_res_o    (f_res_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  // Reference: value = (128+f) * K * 2^(e - 127 - 7 - 15 + eoff); keep the
  // top 8 significant bits of the exact integer product, round half-even
  // by comparing the discarded remainder against half an ulp.
  function automatic logic [15:0] model(input logic s, input logic [7:0] e,
                                        input logic [6:0] f, input logic [1:0] sel);
    longint p, q, rem, half;
    int     msb, sh, ex, k, eoff;
    if (e == 8'd255) return (f == 7'd0) ? {s, 8'hFF, 7'd0} : 16'h7FC0;
    if (e == 8'd0) return {s, 15'd0};
    if (sel == 2'd0 || sel == 2'd3) return {s, e, f};
    k    = (sel == 2'd1) ? 45426 : 39457;
    eoff = (sel == 2'd1) ? -1 : -2;
    p    = longint'(128 + int'(f)) * longint'(k);
    msb  = 23;
    while (msb > 0 && p < (longint'(1) << msb)) msb--;
    sh   = msb - 7;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    ex = int'(e) + eoff + (msb - 22);
    if (q == 256) begin
      q = 128;
      ex++;
    end
    if (ex <= 0) return {s, 15'd0};
    return {s, ex[7:0], 7'(q - 128)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Stream checker sampling 2 time units before each rising edge
  task automatic monitor();
    forever begin
      @(negedge clk);
      #3;
      if (valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected result: got %h, required none",
                   {s_res_o, e_res_o, f_res_o});
        end else begin
          checkOutput("stream result", {16'd0, s_res_o, e_res_o, f_res_o}, {16'd0, exp_q[0]});
        end
      end
      if (rst === 1'b1) begin
        exp_q.delete();
      end else begin
        if (valid_o === 1'b1 && ready_i === 1'b1 && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          emitted++;
        end
        if (valid_i === 1'b1 && ready_o === 1'b1)
          exp_q.push_back(model(s_op_i, e_op_i, f_op_i, base_sel_i));
      end
    end
  endtask

  // Presents an operand (called just after a rising edge) and returns
  // 1 time unit after the edge that accepted it; valid_i stays high.
  task automatic applyStimulus(input logic s, input logic [7:0] e,
                               input logic [6:0] f, input logic [1:0] sel);
    bit got = 1'b0;
    s_op_i     = s;
    e_op_i     = e;
    f_op_i     = f;
    base_sel_i = sel;
    valid_i    = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #4;
      got = ready_o;
    end
    checkOutput("accept within bound", {31'd0, got}, 32'd1);
    if (got) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runDirected(input string name, input logic s, input logic [7:0] e,
                             input logic [6:0] f, input logic [1:0] sel, input logic [15:0] req);
    applyStimulus(s, e, f, sel);
    valid_i = 1'b0;
    checkOutput({name, " valid after 1"}, {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput({name, " valid after 2"}, {31'd0, valid_o}, 32'd1);
    checkOutput({name, " result"}, {16'd0, s_res_o, e_res_o, f_res_o}, {16'd0, req});
    checkOutput({name, " model"}, {16'd0, model(s, e, f, sel)}, {16'd0, req});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          base;
    logic [15:0] hold;
    bit          seen;

    rst        = 1'b1;
    valid_i    = 1'b0;
    ready_i    = 1'b1;
    s_op_i     = 1'b0;
    e_op_i     = 8'd0;
    f_op_i     = 7'd0;
    base_sel_i = 2'd0;

    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset valid_o", {31'd0, valid_o}, 32'd0);
    checkOutput("reset ready_o", {31'd0, ready_o}, 32'd0);
    checkOutput("reset result", {16'd0, s_res_o, e_res_o, f_res_o}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready after reset", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;

    // Directed literal cases
    runDirected("ln 1.0",        1'b0, 8'd127, 7'd0,         2'd1, 16'h3F31);
    runDirected("ln 2.0",        1'b0, 8'd128, 7'd0,         2'd1, 16'h3FB1);
    runDirected("ln round up",   1'b0, 8'd127, 7'd1,         2'd1, 16'h3F33);
    runDirected("ln norm shift", 1'b0, 8'd127, 7'd127,       2'd1, 16'h3FB1);
    runDirected("log10 8.0",     1'b0, 8'd130, 7'd0,         2'd2, 16'h401A);
    runDirected("log10 min exp", 1'b0, 8'd3,   7'd0,         2'd2, 16'h009A);
    runDirected("log10 flush",   1'b0, 8'd2,   7'd0,         2'd2, 16'h0000);
    runDirected("ln flush",      1'b0, 8'd1,   7'd0,         2'd1, 16'h0000);
    runDirected("ln -inf",       1'b1, 8'd255, 7'd0,         2'd1, 16'hFF80);
    runDirected("ln nan",        1'b0, 8'd255, 7'b0111111,   2'd1, 16'h7FC0);
    runDirected("ln zero",       1'b0, 8'd0,   7'd0,         2'd1, 16'h0000);
    runDirected("ln subnormal",  1'b1, 8'd0,   7'b0101010,   2'd1, 16'h8000);
    runDirected("pass sel0",     1'b0, 8'd251, 7'b0101011,   2'd0, 16'h7DAB);
    runDirected("pass sel3",     1'b0, 8'd251, 7'b0101011,   2'd3, 16'h7DAB);

    // Back-to-back with alternating base select
    base = emitted;
    applyStimulus(1'b0, 8'd130, 7'd0,  2'd1);
    applyStimulus(1'b0, 8'd130, 7'd0,  2'd2);
    applyStimulus(1'b0, 8'd130, 7'd0,  2'd0);
    applyStimulus(1'b1, 8'd100, 7'h55, 2'd3);
    applyStimulus(1'b1, 8'd100, 7'h55, 2'd1);
    applyStimulus(1'b1, 8'd100, 7'h55, 2'd2);
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("alternating count", emitted - base, 32'd6);

    // Backpressure: sink stalls for 5 cycles once the first result shows
    base = emitted;
    fork
      begin
        applyStimulus(1'b0, 8'd127, 7'd0,  2'd1);
        applyStimulus(1'b0, 8'd130, 7'd0,  2'd2);
        applyStimulus(1'b1, 8'd90,  7'd33, 2'd0);
        applyStimulus(1'b0, 8'd200, 7'd99, 2'd1);
        valid_i = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          seen = valid_o;
        end
        checkOutput("bp first valid", {31'd0, seen}, 32'd1);
        ready_i = 1'b0;
        #1;
        hold = {s_res_o, e_res_o, f_res_o};
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          #1;
          checkOutput("bp ready_o low", {31'd0, ready_o}, 32'd0);
          checkOutput("bp valid held", {31'd0, valid_o}, 32'd1);
          checkOutput("bp result stable", {16'd0, s_res_o, e_res_o, f_res_o}, {16'd0, hold});
        end
        ready_i = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    checkOutput("bp count", emitted - base, 32'd4);

    // Reset with two operands in the pipe; neither may be delivered
    base    = emitted;
    ready_i = 1'b0;
    applyStimulus(1'b0, 8'd140, 7'd12, 2'd1);
    applyStimulus(1'b1, 8'd141, 7'd13, 2'd2);
    valid_i = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid reset valid_o", {31'd0, valid_o}, 32'd0);
    checkOutput("mid reset result", {16'd0, s_res_o, e_res_o, f_res_o}, 32'd0);
    checkOutput("mid reset ready_o", {31'd0, ready_o}, 32'd0);
    rst     = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    runDirected("post reset ln 1.0", 1'b0, 8'd127, 7'd0, 2'd1, 16'h3F31);
    checkOutput("reset discard count", emitted - base, 32'd1);

    // Random sweep: 1000 normal operands per base under random backpressure
    base     = emitted;
    sweep_on = 1'b1;
    fork
      begin
        while (sweep_on) begin
          @(negedge clk);
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int b = 0; b < 3; b++) begin
          for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          (i % 10 == 0) ? 8'($urandom_range(1, 4)) : 8'($urandom_range(1, 254)),
                          7'($urandom_range(0, 127)),
                          2'(b));
          end
        end
        valid_i  = 1'b0;
        sweep_on = 1'b0;
      end
    join
    ready_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("sweep count", emitted - base, 32'd3000);
    checkOutput("scoreboard drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
